spi_slave: RTL
==============

# spi_slave

SPI responder for the 12-bit SPI link: the far end of the existing SPI master. Samples `sclk`/`cs`/`mosi` from the master, synchronised into the local `clk` domain, and assembles LSB-first frames into `dout` with a one-cycle `done` strobe. Optionally returns a preloaded word on `miso` during the same frame. Sits beside the master inside `top` and is the block that produces `dout`/`done`.

## Interface
- `WIDTH`, 12: frame length in bits.
- `SYNC_STAGES`, 2: flop stages on each of `sclk`, `cs`, `mosi` (minimum 2).
- `clk` input 1: system clock; all logic on rising edge.
- `reset` input 1: asynchronous, active-low; all state cleared while low.
- `sclk` input 1: SPI clock from master; idle low (mode 0).
- `cs` input 1: chip select, active-low.
- `mosi` input 1: serial data from master.
- `miso` output 1: serial data to master.
- `miso_oe` output 1: high while `cs` (synchronised) is low and TX path present.
- `dout` output WIDTH: last complete received frame.
- `done` output 1: one-cycle pulse when `dout` updates.
- `abort` output 1: one-cycle pulse when `cs` rises mid-frame.
- `tx_data` input WIDTH: word to return in the next frame.
- `tx_valid` input 1: `tx_data` valid.
- `tx_ready` output 1: holding register empty.

## Operation
- Inputs pass through `SYNC_STAGES` flops. Edge detect compares the last two synchronised samples.
- Mode 0, LSB first: `mosi` sampled on `sclk` rise; `miso` changes on `sclk` fall.
- FSM:
  - IDLE: waits for a `cs` fall, then clears the bit counter and enters SHIFT.
  - SHIFT: each `sclk` rise shifts `mosi` into bit WIDTH-1 of the rx shift register (right shift) and increments the counter. At count WIDTH it copies to `dout`, pulses `done`, and enters WAIT_CS.
  - WAIT_CS: ignores `sclk` until `cs` rises, then returns to IDLE.
- `cs` rise in SHIFT with 0 < count < WIDTH: pulse `abort`, leave `dout` unchanged, go to IDLE. With count 0: go to IDLE, no pulse.
- TX: one-entry holding register.
  - Handshake `tx_valid && tx_ready` latches `tx_data` and clears `tx_ready`.
  - On `cs` fall, the tx shift register loads the holding value (sets `tx_ready`), or all zeros if empty. `miso` = tx shift bit 0.
  - Each `sclk` fall in SHIFT shifts the tx register right, filling with 0.
  - A handshake in the same cycle as the `cs`-fall load: the load takes the old contents (or zeros); the new word stays held for the next frame.
- `miso` = 0 whenever `miso_oe` is low.
- `sclk` edges while `cs` is high are ignored.

## Timing
- Reset values: `dout`=0, `done`=0, `abort`=0, `miso`=0, `miso_oe`=0, `tx_ready`=1. FSM in IDLE, shift registers and counter 0.
- Latency from pin edge to internal action: `SYNC_STAGES`+1 `clk` cycles.
- `done` asserts `SYNC_STAGES`+1 cycles after the WIDTH-th `sclk` rise. `dout` is valid in the same cycle and holds until the next `done`.
- `miso` updates `SYNC_STAGES`+1 cycles after the `sclk` fall or `cs` fall.
- `sclk` high and low phases must each be ≥ `SYNC_STAGES`+2 `clk` periods. `cs` fall to first `sclk` rise must also be ≥ `SYNC_STAGES`+2 periods.
- Reset mid-frame: immediate return to reset values. The next frame begins only on a fresh `cs` fall.

## Configuration
- `SPI_SLAVE_TX_EN` defined: TX path, `tx_*` handshake, and `miso_oe` as described.
- Not defined: TX logic removed. `miso`=0, `miso_oe`=0, `tx_ready`=0, and `tx_data`/`tx_valid` are ignored. RX behaviour is identical.

## Test plan
- Reset held low with `sclk` toggling -> all outputs at reset values. After release, `tx_ready`=1.
- Frame 12'd5 LSB-first, `sclk` period 100 ns with 10 ns `clk` -> one `done` pulse, `dout`=12'h005, `abort` never high.
- Preload `tx_data`=12'hA5C, then a frame carrying 12'h3F0 -> `miso` bits on successive rises are 0,0,1,1,1,0,1,0,0,1,0,1. `dout`=12'h3F0 and `tx_ready`=1 after `cs` fall.
- `cs` rises after 7 bits -> one `abort` pulse, no `done`, `dout` keeps its prior value. The next full frame of 12'hFFF gives `dout`=12'hFFF.
- 14 `sclk` pulses in one `cs`-low window carrying 12'h0F0 plus extras -> single `done`, `dout`=12'h0F0, extra edges ignored.
- Built without `SPI_SLAVE_TX_EN`: `miso` stays 0 across the 12'h005 frame, `tx_ready`=0, and `dout`=12'h005.

Source files
------------

// File: rtl/spi_slave.sv
// spi_slave: mode-0, LSB-first SPI responder for the 12-bit link.
// The sclk/cs/mosi pins are synchronised into the clk domain. The block
// assembles each frame into dout and pulses done once per complete frame.
// It pulses abort when cs rises part-way through a frame.
// Optional TX path, enabled by defining SPI_SLAVE_TX_EN: a one-entry holding
// register is loaded by a valid/ready handshake and shifted out on miso
// during the next frame. Without the macro, miso, miso_oe and tx_ready are
// tied low and tx_data/tx_valid are ignored.
module spi_slave #(
    parameter int WIDTH       = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sclk,
    input  logic             cs,
    input  logic             mosi,
    output logic             miso,
    output logic             miso_oe,
    output logic [WIDTH-1:0] dout,
    output logic             done,
    output logic             abort,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        WAIT_CS = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sclk_s, cs_s, mosi_s;
    logic                   sclk_d, cs_d;
    logic                   sclk_rise, cs_fall, cs_rise, mosi_q;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rx_sr;
    logic             cnt_clr, shift_en, done_set, abort_set;

    // Synchronisers. cs resets low so that a cs already held low across reset
    // is never mistaken for a fresh frame start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk_s <= '0;
            cs_s   <= '0;
            mosi_s <= '0;
            sclk_d <= 1'b0;
            cs_d   <= 1'b0;
        end else begin
            sclk_s <= {sclk_s[SYNC_STAGES-2:0], sclk};
            cs_s   <= {cs_s[SYNC_STAGES-2:0], cs};
            mosi_s <= {mosi_s[SYNC_STAGES-2:0], mosi};
            sclk_d <= sclk_s[SYNC_STAGES-1];
            cs_d   <= cs_s[SYNC_STAGES-1];
        end
    end

    assign sclk_rise = sclk_s[SYNC_STAGES-1] & ~sclk_d;
    assign cs_fall   = ~cs_s[SYNC_STAGES-1] & cs_d;
    assign cs_rise   = cs_s[SYNC_STAGES-1] & ~cs_d;
    assign mosi_q    = mosi_s[SYNC_STAGES-1];

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and per-cycle control strobes. A cs rise beats a coincident
    // sclk rise, so a frame is never completed by a deselected master.
    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        shift_en  = 1'b0;
        done_set  = 1'b0;
        abort_set = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    cnt_clr   = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    abort_set = (cnt != '0);
                    state_nxt = IDLE;
                end else if (sclk_rise) begin
                    shift_en = 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        done_set  = 1'b1;
                        state_nxt = WAIT_CS;
                    end
                end
            end
            WAIT_CS: begin
                if (cs_rise) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // RX datapath: right-shift register, bit counter, and the frame output.
    // dout takes the final mosi bit directly, so it is valid alongside done.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_sr <= '0;
            cnt   <= '0;
            dout  <= '0;
            done  <= 1'b0;
            abort <= 1'b0;
        end else begin
            done  <= done_set;
            abort <= abort_set;
            if (cnt_clr) begin
                cnt <= '0;
            end else if (shift_en) begin
                cnt   <= cnt + 1'b1;
                rx_sr <= {mosi_q, rx_sr[WIDTH-1:1]};
            end
            if (done_set) dout <= {mosi_q, rx_sr[WIDTH-1:1]};
        end
    end

`ifdef SPI_SLAVE_TX_EN
    logic [WIDTH-1:0] tx_hold, tx_sr;
    logic             tx_full, oe, sclk_fall, frame_start;

    assign sclk_fall   = ~sclk_s[SYNC_STAGES-1] & sclk_d;
    assign frame_start = (state == IDLE) && cs_fall;

    // TX holding register, shift register and output enable. At a frame
    // start the shifter takes the word held before this cycle. A handshake
    // in the same cycle refills the holding register for the next frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_hold <= '0;
            tx_sr   <= '0;
            tx_full <= 1'b0;
            oe      <= 1'b0;
        end else begin
            if (tx_valid && !tx_full) begin
                tx_hold <= tx_data;
                tx_full <= 1'b1;
            end else if (frame_start) begin
                tx_full <= 1'b0;
            end
            if (frame_start) begin
                tx_sr <= tx_full ? tx_hold : '0;
            end else if ((state == SHIFT) && sclk_fall) begin
                tx_sr <= {1'b0, tx_sr[WIDTH-1:1]};
            end
            if (frame_start)  oe <= 1'b1;
            else if (cs_rise) oe <= 1'b0;
        end
    end

    assign miso     = oe & tx_sr[0];
    assign miso_oe  = oe;
    assign tx_ready = ~tx_full;
`else
    logic unused_tx;
    assign unused_tx = ^{tx_data, tx_valid};
    assign miso      = 1'b0;
    assign miso_oe   = 1'b0;
    assign tx_ready  = 1'b0;
`endif

endmodule
